// File: rtl/lab3_cache_pkg.sv
// Shared cache-side definitions: memory request message, type codes,
// line geometry defaults, the batch FSM state enum and a line-alignment helper.
package lab3_cache_pkg;

    localparam int unsigned LINE_WORDS_DEF = 4;
    localparam int unsigned WORD_BYTES     = 4;
    localparam int unsigned WORD_BITS      = WORD_BYTES * 8;
    localparam int unsigned ADDR_BITS      = 32;
    localparam int unsigned TYPE_BITS      = 3;
    localparam int unsigned OPAQUE_BITS    = 8;
    localparam int unsigned LEN_BITS       = 2;

    // Memory request type_ codes
    localparam logic [TYPE_BITS-1:0] READ  = TYPE_BITS'(0);
    localparam logic [TYPE_BITS-1:0] WRITE = TYPE_BITS'(1);

    // Single-word memory request (vc mem message layout)
    typedef struct packed {
        logic [TYPE_BITS-1:0]   type_;
        logic [OPAQUE_BITS-1:0] opaque;
        logic [ADDR_BITS-1:0]   addr;
        logic [LEN_BITS-1:0]    len;
        logic [WORD_BITS-1:0]   data;
    } mem_req_4B_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    // Clear the byte-offset-within-line bits of an address
    function automatic logic [ADDR_BITS-1:0] line_base(
        input logic [ADDR_BITS-1:0] addr,
        input int unsigned          line_words
    );
        logic [ADDR_BITS-1:0] mask;
        mask = ADDR_BITS'(line_words * WORD_BYTES) - ADDR_BITS'(1);
        return addr & ~mask;
    endfunction

endpackage

// File: rtl/lab3_cache_batch_send_if.sv
// Batch-send bus bundle: line-operation istream (val/rdy/rw/addr/data) in,
// word-request ostream (val/rdy/msg) out.
//   master : environment side (drives istream, accepts ostream)
//   slave  : batch-send unit side
interface lab3_cache_batch_send_if
    import lab3_cache_pkg::*;
#(
    parameter int unsigned LINE_WORDS = LINE_WORDS_DEF
);

    logic                            istream_val;
    logic                            istream_rdy;
    logic                            istream_rw;
    logic [ADDR_BITS-1:0]            istream_addr;
    logic [LINE_WORDS*WORD_BITS-1:0] istream_data;

    logic                            ostream_val;
    logic                            ostream_rdy;
    mem_req_4B_t                     ostream_msg;

    modport master (
        output istream_val, istream_rw, istream_addr, istream_data, ostream_rdy,
        input  istream_rdy, ostream_val, ostream_msg
    );

    modport slave (
        input  istream_val, istream_rw, istream_addr, istream_data, ostream_rdy,
        output istream_rdy, ostream_val, ostream_msg
    );

endinterface

// File: rtl/lab3_cache_word_counter.sv
// Word counter for cache-line bursts: synchronous clear (priority) and
// increment, wrapping naturally at N (power of two).
//   clk, reset   clock, asynchronous active-low reset
//   i_clr        force count to 0 on next edge
//   i_inc        advance count on next edge
//   o_cnt        current count (registered)
//   o_wrap_c     count == N-1 (combinational decode of the register)
module lab3_cache_word_counter #(
    parameter int unsigned N = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_clr,
    input  logic                 i_inc,
    output logic [$clog2(N)-1:0] o_cnt,
    output logic                 o_wrap_c
);

    localparam int unsigned CW = $clog2(N);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign o_cnt    = r_cnt;
    assign o_wrap_c = (r_cnt == CW'(N - 1));

endmodule

// File: rtl/lab3_cache_batch_send.sv
// Cache batch-send unit: serializes one line operation (evict = write line,
// refill = read line) into LINE_WORDS single-word memory requests issued in
// ascending word order.
//   clk    clock
//   reset  asynchronous active-low reset
//   bus    lab3_cache_batch_send_if.slave (istream in, ostream out)
// Build option: LAB3_CACHE_BATCH_SEND_BYPASS_EN lets the next line operation
// be accepted on the cycle the last word is accepted, removing the bubble
// between bursts.
module lab3_cache_batch_send
    import lab3_cache_pkg::*;
#(
    parameter int unsigned LINE_WORDS = LINE_WORDS_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    lab3_cache_batch_send_if.slave bus
);

    localparam int unsigned CNT_BITS = $clog2(LINE_WORDS);

    state_e                                r_state;
    state_e                                w_state_nxt;
    logic                                  r_live;
    logic                                  r_rw;
    logic [ADDR_BITS-1:0]                  r_base;
    logic [LINE_WORDS-1:0][WORD_BITS-1:0]  r_data;

    logic [CNT_BITS-1:0]                   w_cnt;
    logic                                  w_wrap;
    logic                                  w_clr;
    logic                                  w_inc;
    logic                                  w_accept;
    logic                                  w_istream_rdy;
    logic                                  w_ostream_val;
    mem_req_4B_t                           w_msg;

    // Word counter: index of the word currently offered downstream
    lab3_cache_word_counter #(
        .N (LINE_WORDS)
    ) u_cnt (
        .clk      (clk),
        .reset    (reset),
        .i_clr    (w_clr),
        .i_inc    (w_inc),
        .o_cnt    (w_cnt),
        .o_wrap_c (w_wrap)
    );

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Holds istream_rdy low through reset; rdy first appears one clock after release
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_live <= 1'b0;
        end else begin
            r_live <= 1'b1;
        end
    end

    // Line operation latch, loaded only on the accept handshake
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rw   <= 1'b0;
            r_base <= '0;
            r_data <= '0;
        end else if (w_accept) begin
            r_rw   <= bus.istream_rw;
            r_base <= line_base(bus.istream_addr, LINE_WORDS);
            r_data <= bus.istream_data;
        end
    end

    // Next-state and handshake decode
    always_comb begin
        w_state_nxt   = r_state;
        w_istream_rdy = 1'b0;
        w_ostream_val = 1'b0;
        w_accept      = 1'b0;
        w_clr         = 1'b0;
        w_inc         = 1'b0;

        case (r_state)
            IDLE: begin
                w_istream_rdy = r_live;
                if (bus.istream_val && w_istream_rdy) begin
                    w_accept    = 1'b1;
                    w_clr       = 1'b1;
                    w_state_nxt = SEND;
                end
            end

            SEND: begin
                w_ostream_val = 1'b1;
`ifdef LAB3_CACHE_BATCH_SEND_BYPASS_EN
                // Ready only as the final word leaves, so no word is ever left behind
                w_istream_rdy = w_wrap && bus.ostream_rdy;
`endif
                if (bus.ostream_rdy) begin
                    if (w_wrap) begin
                        w_clr       = 1'b1;
                        w_state_nxt = IDLE;
                    end else begin
                        w_inc = 1'b1;
                    end
                end
`ifdef LAB3_CACHE_BATCH_SEND_BYPASS_EN
                // Back-to-back line: reload and restart at word 0 without leaving SEND
                if (bus.istream_val && w_istream_rdy) begin
                    w_accept    = 1'b1;
                    w_clr       = 1'b1;
                    w_state_nxt = SEND;
                end
`endif
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Word request built from latched line state; stable while stalled
    always_comb begin
        w_msg        = '0;
        w_msg.type_  = r_rw ? WRITE : READ;
        w_msg.opaque = OPAQUE_BITS'(w_cnt);
        w_msg.addr   = r_base + ADDR_BITS'(w_cnt) * ADDR_BITS'(WORD_BYTES);
        w_msg.len    = '0;
        w_msg.data   = r_rw ? r_data[w_cnt] : '0;
    end

    assign bus.istream_rdy = w_istream_rdy;
    assign bus.ostream_val = w_ostream_val;
    assign bus.ostream_msg = w_msg;

endmodule

// File: tb/tb_lab3_cache_batch_send.sv
// Bench for lab3_cache_batch_send: directed scenarios plus randomized line
// operations with random downstream backpressure, checked every cycle
// against a queue-based model of the word requests each line must produce.
module tb_lab3_cache_batch_send;
    import lab3_cache_pkg::*;

    localparam int unsigned LW = LINE_WORDS_DEF;

`ifdef LAB3_CACHE_BATCH_SEND_BYPASS_EN
    localparam int EXP_BUBBLE = 0;
`else
    localparam int EXP_BUBBLE = 1;
`endif

    logic clk;
    logic reset;

    lab3_cache_batch_send_if #(.LINE_WORDS(LW)) bus ();

    lab3_cache_batch_send #(.LINE_WORDS(LW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    mem_req_4B_t exp_q[$];
    int          fire_cyc[$];
    int          cyc   = 0;
    int          n_out = 0;
    int          n_acc = 0;
    bit          live  = 1'b0;
    bit          exp_val;
    bit          exp_rdy;
    logic [31:0] last_addr = '0;
    int          rdy_mode  = 0;
    int          tgl       = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Expected request for word i of a line operation, straight from the rules
    function automatic mem_req_4B_t exp_word(input logic rw, input logic [31:0] addr,
                                             input logic [LW*32-1:0] data, input int i);
        mem_req_4B_t m;
        logic [31:0] base;
        base     = addr - (addr % 32'(LW * 4));
        m.type_  = rw ? WRITE : READ;
        m.opaque = 8'(i);
        m.addr   = base + 32'(4 * i);
        m.len    = 2'd0;
        m.data   = rw ? data[32*i +: 32] : 32'd0;
        return m;
    endfunction

    function automatic logic [LW*32-1:0] rand_line();
        logic [LW*32-1:0] r;
        for (int i = 0; i < int'(LW); i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    // Monitor: check outputs mid-cycle, then advance the model over the coming edge
    always @(negedge clk) begin
        cyc++;
        if (!reset) begin
            chk("rst_oval", 128'(bus.ostream_val), 128'(1'b0));
            chk("rst_irdy", 128'(bus.istream_rdy), 128'(1'b0));
            exp_q.delete();
            live = 1'b0;
        end else begin
            exp_val = (exp_q.size() != 0);
`ifdef LAB3_CACHE_BATCH_SEND_BYPASS_EN
            exp_rdy = live && (exp_q.size() == 0 || (exp_q.size() == 1 && bus.ostream_rdy));
`else
            exp_rdy = live && (exp_q.size() == 0);
`endif
            chk("oval", 128'(bus.ostream_val), 128'(exp_val));
            chk("irdy", 128'(bus.istream_rdy), 128'(exp_rdy));
            if (exp_val) begin
                chk("omsg", 128'(bus.ostream_msg), 128'(exp_q[0]));
                if (bus.ostream_rdy) begin
                    void'(exp_q.pop_front());
                    n_out++;
                    fire_cyc.push_back(cyc);
                    last_addr = bus.ostream_msg.addr;
                end
            end
            if (bus.istream_val && exp_rdy) begin
                for (int i = 0; i < int'(LW); i++)
                    exp_q.push_back(exp_word(bus.istream_rw, bus.istream_addr, bus.istream_data, i));
                n_acc++;
            end
            live = 1'b1;
        end
    end

    // Advance one cycle; inputs change 2ns after the rising edge
    task automatic tick();
        @(posedge clk);
        #2;
        case (rdy_mode)
            1:       bus.ostream_rdy = 1'($urandom_range(0, 1));
            2: begin bus.ostream_rdy = (tgl % 3 == 0); tgl++; end
            default: bus.ostream_rdy = 1'b1;
        endcase
    endtask

    // Present one line operation until accepted; optionally keep val high afterwards
    task automatic send_op(input logic rw, input logic [31:0] addr,
                           input logic [LW*32-1:0] data, input bit hold);
        int start;
        start            = n_acc;
        bus.istream_val  = 1'b1;
        bus.istream_rw   = rw;
        bus.istream_addr = addr;
        bus.istream_data = data;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (n_acc != start) break;
        end
        chk("accept", 128'(n_acc - start), 128'(1));
        if (!hold) begin
            bus.istream_val  = 1'b0;
            bus.istream_rw   = 1'($urandom_range(0, 1));
            bus.istream_addr = $urandom;
            bus.istream_data = rand_line();
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 300; i++) begin
            if (exp_q.size() == 0 && !bus.ostream_val) break;
            tick();
        end
        chk("drain", 128'(exp_q.size()), 128'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int idx;
        bit prev_hold;
        logic [LW*32-1:0] line;

        reset            = 1'b0;
        bus.istream_val  = 1'b0;
        bus.istream_rw   = 1'b0;
        bus.istream_addr = '0;
        bus.istream_data = '0;
        bus.ostream_rdy  = 1'b1;

        repeat (3) tick();
        chk("reset_rdy", 128'(bus.istream_rdy), 128'(0));
        chk("reset_val", 128'(bus.ostream_val), 128'(0));
        reset = 1'b1;
        tick();
        chk("post_reset_rdy", 128'(bus.istream_rdy), 128'(1));

        // Write burst, no backpressure: four contiguous cycles
        base = n_out;
        line = {32'hDDDD_0003, 32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000};
        send_op(1'b1, 32'h0000_100C, line, 1'b0);
        drain();
        chk("wr_words", 128'(n_out - base), 128'(4));
        idx = fire_cyc.size();
        chk("wr_span", 128'(fire_cyc[idx-1] - fire_cyc[idx-4]), 128'(3));
        chk("wr_last_addr", 128'(last_addr), 128'(32'h0000_100C));
        tick();
        chk("wr_rdy_back", 128'(bus.istream_rdy), 128'(1));

        // Read burst with 1,0,0 backpressure pattern
        rdy_mode = 2;
        tgl      = 0;
        base     = n_out;
        send_op(1'b0, 32'h0000_2000, rand_line(), 1'b0);
        drain();
        chk("rd_words", 128'(n_out - base), 128'(4));
        rdy_mode        = 0;
        bus.ostream_rdy = 1'b1;

        // Evict then refill with val held across both
        base = n_out;
        idx  = fire_cyc.size();
        send_op(1'b1, 32'h0000_3004, rand_line(), 1'b1);
        send_op(1'b0, 32'h0000_4000, rand_line(), 1'b0);
        drain();
        chk("er_words", 128'(n_out - base), 128'(8));
        chk("er_bubble", 128'(fire_cyc[idx+4] - fire_cyc[idx+3] - 1), 128'(EXP_BUBBLE));

        // Reset mid-burst after word 1 accepted
        base = n_out;
        send_op(1'b1, 32'h0000_5000, rand_line(), 1'b0);
        for (int i = 0; i < 50; i++) begin
            if (n_out - base >= 2) break;
            tick();
        end
        chk("mid_words", 128'(n_out - base), 128'(2));
        reset = 1'b0;
        #1;
        chk("mid_val_drop", 128'(bus.ostream_val), 128'(0));
        chk("mid_rdy_low", 128'(bus.istream_rdy), 128'(0));
        tick();
        tick();
        reset = 1'b1;
        tick();
        chk("rel_rdy", 128'(bus.istream_rdy), 128'(1));
        chk("rel_val", 128'(bus.ostream_val), 128'(0));
        base = n_out;
        send_op(1'b0, 32'h0000_6008, rand_line(), 1'b0);
        drain();
        chk("rel_words", 128'(n_out - base), 128'(4));

        // Line at top of address space
        send_op(1'b1, 32'hFFFF_FFF4, rand_line(), 1'b0);
        drain();
        chk("wrap_last_addr", 128'(last_addr), 128'(32'hFFFF_FFFC));

        // Idle hygiene
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("idle_rdy", 128'(bus.istream_rdy), 128'(1));
            chk("idle_val", 128'(bus.ostream_val), 128'(0));
        end

        // Random operations, random backpressure, random back-to-back
        rdy_mode  = 1;
        base      = n_out;
        prev_hold = 1'b0;
        for (int k = 0; k < 30; k++) begin
            bit hold;
            hold = (k != 29) && ($urandom_range(0, 1) == 1);
            if (!prev_hold) repeat ($urandom_range(0, 3)) tick();
            send_op(1'($urandom_range(0, 1)), $urandom, rand_line(), hold);
            prev_hold = hold;
        end
        drain();
        chk("rand_words", 128'(n_out - base), 128'(30 * LW));
        rdy_mode        = 0;
        bus.ostream_rdy = 1'b1;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
